// File: rtl/bilinear_sequencer_pkg.sv
// Shared types and constants for the bilinear downscaling sequencer.
package bilinear_sequencer_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ROW,
      S_STEPW,
      S_FETCH,
      S_CALC,
      S_WRITE,
      S_ADV,
      S_DONE
   } state_e;

   localparam logic [1:0]  MODE_BILINEAR = 2'b00;
   localparam logic [1:0]  MODE_NEAREST  = 2'b01;
   localparam int          FRAC_W        = 8;
   localparam logic [15:0] SCALE_ONE     = 16'h0100;

   // Neighbour coordinate clamped to the last valid column/row: min(c+1, lim-1).
   function automatic logic [15:0] clamp_next(input logic [15:0] c, input logic [15:0] lim);
      return (c >= lim - 16'd1) ? lim - 16'd1 : c + 16'd1;
   endfunction

endpackage

// File: rtl/bilinear_sequencer_if.sv
// Single-port pixel RAM bus: one read or one write per cycle, read data one cycle after mem_re.
interface bilinear_sequencer_if #(
   parameter int ADDR_W = 16
);
   logic [ADDR_W-1:0] addr;
   logic              re;
   logic [7:0]        rdata;
   logic              we;
   logic [7:0]        wdata;

   modport master (output addr, re, we, wdata, input rdata);
   modport slave  (input addr, re, we, wdata, output rdata);
endinterface

// File: rtl/bilinear_sequencer_interp.sv
// Combinational bilinear blend of a 2x2 neighbourhood with 8-bit fractional weights.
module bilinear_interp (
   input  logic [7:0] p00_i,
   input  logic [7:0] p01_i,
   input  logic [7:0] p10_i,
   input  logic [7:0] p11_i,
   input  logic [7:0] fx_i,
   input  logic [7:0] fy_i,
   output logic [7:0] r_o
);
   function automatic logic [15:0] lerp8(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] f);
      logic [16:0] wa, wb;
      wa = {9'd0, a} * (17'd256 - {9'd0, f});
      wb = {9'd0, b} * {9'd0, f};
      return 16'(wa + wb);
   endfunction

   // Round half up from Q.16 down to an 8-bit pixel.
   function automatic logic [7:0] round_q16(input logic [24:0] acc);
      return 8'((acc + 25'h008000) >> 16);
   endfunction

   logic [15:0] h, v;
   logic [24:0] mix;

   assign h   = lerp8(p00_i, p01_i, fx_i);
   assign v   = lerp8(p10_i, p11_i, fx_i);
   assign mix = {9'd0, h} * (25'd256 - {17'd0, fy_i}) + {9'd0, v} * {17'd0, fy_i};
   assign r_o = round_q16(mix);
endmodule

// File: rtl/bilinear_sequencer.sv
// Bilinear/nearest downscaler: walks the output grid, fetches source pixels over the
// RAM bus and writes results sequentially into the destination region.
module bilinear_sequencer
   import bilinear_sequencer_pkg::*;
#(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] SRC_BASE = '0,
   parameter logic [ADDR_W-1:0] DST_BASE = ADDR_W'(16'h8000)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic                 step_mode_i,
   input  logic                 step_pulse_i,
   input  logic [15:0]          cfg_width_i,
   input  logic [15:0]          cfg_height_i,
   input  logic [15:0]          cfg_scale_i,
   input  logic [7:0]           cfg_mode_i,
   bilinear_sequencer_if.master mem,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o,
   output logic [15:0]          pix_count_o
);
   state_e            state_q, state_d;
   logic [23:0]       acc_x_q, acc_x_d, acc_y_q, acc_y_d;
   logic [15:0]       pix_count_q, pix_count_d;
   logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic [1:0]        fcnt_q, fcnt_d, rd_idx_q;
   logic              rd_vld_q;

   logic [15:0]       w_q, h_q, scale_q;
   logic              near_q;
   logic [ADDR_W-1:0] rb0_q, rb1_q;
   logic [7:0]        pix_q [4];
   logic [7:0]        pix_now [4];
   logic [7:0]        result_q, interp_r;

   logic              cfg_ld, rb_ld, res_ld, cfg_bad, x_over, y_over;
   logic [15:0]       x0, x1, y0, y1;
   logic [24:0]       sum_x, sum_y;
   logic              unused_mode_bits;

   assign unused_mode_bits = ^{cfg_mode_i[7:3], cfg_mode_i[0]};
   assign cfg_bad = (cfg_width_i == '0) || (cfg_height_i == '0) ||
                    (cfg_scale_i < SCALE_ONE) || cfg_mode_i[2];

   assign x0     = acc_x_q[23:FRAC_W];
   assign y0     = acc_y_q[23:FRAC_W];
   assign x1     = clamp_next(x0, w_q);
   assign y1     = clamp_next(y0, h_q);
   // 25-bit sums so a carry out of the accumulator also counts as leaving the image.
   assign sum_x  = {1'b0, acc_x_q} + {9'd0, scale_q};
   assign sum_y  = {1'b0, acc_y_q} + {9'd0, scale_q};
   assign x_over = sum_x[24] || (sum_x[23:FRAC_W] >= w_q);
   assign y_over = sum_y[24] || (sum_y[23:FRAC_W] >= h_q);

   // The final sample of a pixel is used straight off the bus in CALC.
   always_comb begin
      pix_now = pix_q;
      if (rd_vld_q) pix_now[rd_idx_q] = mem.rdata;
   end

   bilinear_interp u_interp (
      .p00_i (pix_now[0]),
      .p01_i (pix_now[1]),
      .p10_i (pix_now[2]),
      .p11_i (pix_now[3]),
      .fx_i  (acc_x_q[FRAC_W-1:0]),
      .fy_i  (acc_y_q[FRAC_W-1:0]),
      .r_o   (interp_r)
   );

   always_comb begin
      state_d     = state_q;
      acc_x_d     = acc_x_q;
      acc_y_d     = acc_y_q;
      pix_count_d = pix_count_q;
      busy_d      = busy_q;
      done_d      = done_q;
      err_d       = err_q;
      fcnt_d      = fcnt_q;
      cfg_ld      = 1'b0;
      rb_ld       = 1'b0;
      res_ld      = 1'b0;
      mem.addr    = '0;
      mem.re      = 1'b0;
      mem.we      = 1'b0;
      mem.wdata   = '0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               cfg_ld      = 1'b1;
               acc_x_d     = '0;
               acc_y_d     = '0;
               pix_count_d = '0;
               if (cfg_bad) begin
                  err_d   = 1'b1;
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  err_d   = 1'b0;
                  done_d  = 1'b0;
                  busy_d  = 1'b1;
                  state_d = S_ROW;
               end
            end
         end
         S_ROW: begin
            rb_ld   = 1'b1;
            state_d = step_mode_i ? S_STEPW : S_FETCH;
         end
         S_STEPW: begin
            if (!step_mode_i || step_pulse_i) state_d = S_FETCH;
         end
         S_FETCH: begin
            mem.re = 1'b1;
            case (fcnt_q)
               2'd0:    mem.addr = SRC_BASE + rb0_q + ADDR_W'(x0);
               2'd1:    mem.addr = SRC_BASE + rb0_q + ADDR_W'(x1);
               2'd2:    mem.addr = SRC_BASE + rb1_q + ADDR_W'(x0);
               default: mem.addr = SRC_BASE + rb1_q + ADDR_W'(x1);
            endcase
            if (near_q || fcnt_q == 2'd3) begin
               fcnt_d  = '0;
               state_d = S_CALC;
            end else begin
               fcnt_d  = fcnt_q + 2'd1;
            end
         end
         S_CALC: begin
            res_ld  = 1'b1;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            mem.we      = 1'b1;
            mem.addr    = DST_BASE + ADDR_W'(pix_count_q);
            mem.wdata   = result_q;
            pix_count_d = pix_count_q + 16'd1;
            state_d     = S_ADV;
         end
         S_ADV: begin
            if (x_over) begin
               acc_x_d = '0;
               acc_y_d = sum_y[23:0];
               if (y_over) begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_ROW;
               end
            end else begin
               acc_x_d = sum_x[23:0];
               state_d = step_mode_i ? S_STEPW : S_FETCH;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         acc_x_q     <= '0;
         acc_y_q     <= '0;
         pix_count_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         fcnt_q      <= '0;
         rd_vld_q    <= 1'b0;
         rd_idx_q    <= '0;
      end else begin
         state_q     <= state_d;
         acc_x_q     <= acc_x_d;
         acc_y_q     <= acc_y_d;
         pix_count_q <= pix_count_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         fcnt_q      <= fcnt_d;
         rd_vld_q    <= mem.re;
         rd_idx_q    <= fcnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (cfg_ld) begin
         w_q     <= cfg_width_i;
         h_q     <= cfg_height_i;
         scale_q <= cfg_scale_i;
         near_q  <= (cfg_mode_i[2:1] == MODE_NEAREST);
      end
      if (rb_ld) begin
         rb0_q <= ADDR_W'(32'(y0) * 32'(w_q));
         rb1_q <= ADDR_W'(32'(y1) * 32'(w_q));
      end
      if (rd_vld_q) pix_q[rd_idx_q] <= mem.rdata;
      if (res_ld) result_q <= near_q ? pix_now[0] : interp_r;
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign pix_count_o = pix_count_q;
endmodule
